// File: rtl/simple_tx_reset_pkg.sv
// Shared register map, field positions and response codes for the simple_tx
// loopback reset/control register block.
package simple_tx_reset_pkg;

    // Byte offsets within the 16-byte register window
    localparam logic [3:0] OFFS_CTRL     = 4'h0;
    localparam logic [3:0] OFFS_GPIO_OUT = 4'h4;
    localparam logic [3:0] OFFS_GPIO_IN  = 4'h8;
    localparam logic [3:0] OFFS_SCRATCH  = 4'hC;

    localparam int CTRL_W           = 4;
    localparam int CTRL_COMMON_RST  = 0;
    localparam int CTRL_COMMON_GATE = 1;
    localparam int CTRL_SWITCH_ON   = 2;
    localparam int CTRL_SWITCH_DONE = 3;

    localparam int GPIO_W    = 2;
    localparam int GPIO_OSW0 = 0;
    localparam int GPIO_OSW1 = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Expand four byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/simple_tx_reset_axil_if.sv
// AXI4-Lite slave handshake for single-outstanding transactions; presents a
// simple word-wide write port and a combinational read port to a register file.
module simple_tx_reset_axil_if
    import simple_tx_reset_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_USE_WSTRB        = 0,
    parameter int C_DPHASE_TIMEOUT   = 0
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr,
    input  logic                              awvalid,
    output logic                              awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb,
    input  logic                              wvalid,
    output logic                              wready,
    output logic [1:0]                        bresp,
    output logic                              bvalid,
    input  logic                              bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr,
    input  logic                              arvalid,
    output logic                              arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                        rresp,
    output logic                              rvalid,
    input  logic                              rready,
    output logic                              wr_en,
    output logic [3:0]                        wr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     wr_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   wr_strb,
    output logic [3:0]                        rd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     rd_data
);

    localparam int CNT_W = $clog2(C_DPHASE_TIMEOUT + 2);

    logic                          awready_q;
    logic                          arready_q;
    logic                          bvalid_q;
    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [CNT_W-1:0]              b_cnt;
    logic [CNT_W-1:0]              r_cnt;
    logic                          wr_hs;
    logic                          rd_hs;
    logic                          b_expire;
    logic                          r_expire;
    logic                          unused_addr_bits;

    assign wr_hs = awready_q && awvalid && wvalid;
    assign rd_hs = arready_q && arvalid;

    assign b_expire = (C_DPHASE_TIMEOUT != 0) && !bready &&
                      (b_cnt == CNT_W'(C_DPHASE_TIMEOUT - 1));
    assign r_expire = (C_DPHASE_TIMEOUT != 0) && !rready &&
                      (r_cnt == CNT_W'(C_DPHASE_TIMEOUT - 1));

    // The ready flags are registered, so a request is seen for a cycle before
    // it is accepted; the self-clearing term makes each ready a single pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            awready_q <= awvalid && wvalid && !bvalid_q && !awready_q;
            arready_q <= arvalid && !rvalid_q && !arready_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bvalid_q <= 1'b0;
            b_cnt    <= '0;
        end else if (wr_hs) begin
            bvalid_q <= 1'b1;
            b_cnt    <= '0;
        end else if (bvalid_q && (bready || b_expire)) begin
            bvalid_q <= 1'b0;
        end else if (bvalid_q && (C_DPHASE_TIMEOUT != 0)) begin
            b_cnt <= b_cnt + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            r_cnt    <= '0;
            rdata_q  <= '0;
        end else if (rd_hs) begin
            rvalid_q <= 1'b1;
            r_cnt    <= '0;
            rdata_q  <= rd_data;
        end else if (rvalid_q && (rready || r_expire)) begin
            rvalid_q <= 1'b0;
        end else if (rvalid_q && (C_DPHASE_TIMEOUT != 0)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign awready = awready_q;
    assign wready  = awready_q;
    assign arready = arready_q;
    assign bvalid  = bvalid_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign bresp   = RESP_OKAY;
    assign rresp   = RESP_OKAY;

    assign wr_en   = wr_hs;
    assign wr_addr = {awaddr[3:2], 2'b00};
    assign wr_data = wdata;
    assign wr_strb = (C_USE_WSTRB != 0) ? wstrb : '1;
    assign rd_addr = {araddr[3:2], 2'b00};

    assign unused_addr_bits = ^{awaddr[C_S_AXI_ADDR_WIDTH-1:4], awaddr[1:0],
                                araddr[C_S_AXI_ADDR_WIDTH-1:4], araddr[1:0]};

endmodule

// File: rtl/simple_tx_reset_ctl.sv
// Register file driving the simple_tx loopback reset/gate levels and the
// optical-switch GPIOs, with synchronised switch-status readback.
module simple_tx_reset_ctl
    import simple_tx_reset_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          C_USE_WSTRB        = 0,
    parameter int          C_DPHASE_TIMEOUT   = 0,
    parameter logic [31:0] C_BASEADDR         = 32'hFFFF_FFFF,
    parameter logic [31:0] C_HIGHADDR         = 32'h0000_0000
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              common_rst,
    output logic                              common_gate,
    output logic                              switch_on,
    output logic                              switch_done,
    output logic                              osw_drive0,
    output logic                              osw_drive1,
    input  logic                              osw_status0,
    input  logic                              osw_status1
);

    localparam logic [63:0] unused_addr_range = {C_BASEADDR, C_HIGHADDR};

    logic                          wr_en;
    logic [3:0]                    wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [3:0]                    wr_strb;
    logic [3:0]                    rd_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
    logic [31:0]                   wr_mask;

    logic [CTRL_W-1:0]             ctrl_q;
    logic [GPIO_W-1:0]             gpio_out_q;
    logic [31:0]                   scratch_q;
    logic [GPIO_W-1:0]             status_p0;
    logic [GPIO_W-1:0]             status_p1;

    logic [CTRL_W-1:0]             ctrl_nxt;
    logic [GPIO_W-1:0]             gpio_out_nxt;
    logic [31:0]                   scratch_nxt;

    simple_tx_reset_axil_if #(
        .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .C_USE_WSTRB        (C_USE_WSTRB),
        .C_DPHASE_TIMEOUT   (C_DPHASE_TIMEOUT)
    ) u_axil_if (
        .aclk    (S_AXI_ACLK),
        .aresetn (S_AXI_ARESETN),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bresp   (S_AXI_BRESP),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .araddr  (S_AXI_ARADDR),
        .arvalid (S_AXI_ARVALID),
        .arready (S_AXI_ARREADY),
        .rdata   (S_AXI_RDATA),
        .rresp   (S_AXI_RRESP),
        .rvalid  (S_AXI_RVALID),
        .rready  (S_AXI_RREADY),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Byte-merge each register with the incoming data; all narrow fields live in byte 0
    assign wr_mask      = byte_mask(wr_strb);
    assign ctrl_nxt     = (ctrl_q & ~wr_mask[CTRL_W-1:0]) | (wr_data[CTRL_W-1:0] & wr_mask[CTRL_W-1:0]);
    assign gpio_out_nxt = (gpio_out_q & ~wr_mask[GPIO_W-1:0]) | (wr_data[GPIO_W-1:0] & wr_mask[GPIO_W-1:0]);
    assign scratch_nxt  = (scratch_q & ~wr_mask) | (wr_data & wr_mask);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q     <= '0;
            gpio_out_q <= '0;
            scratch_q  <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                OFFS_CTRL:     ctrl_q     <= ctrl_nxt;
                OFFS_GPIO_OUT: gpio_out_q <= gpio_out_nxt;
                OFFS_SCRATCH:  scratch_q  <= scratch_nxt;
                default:       ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous switch status lines
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            status_p0 <= '0;
            status_p1 <= '0;
        end else begin
            status_p0[GPIO_OSW0] <= osw_status0;
            status_p0[GPIO_OSW1] <= osw_status1;
            status_p1            <= status_p0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            OFFS_CTRL:     rd_data[CTRL_W-1:0] = ctrl_q;
            OFFS_GPIO_OUT: rd_data[GPIO_W-1:0] = gpio_out_q;
            OFFS_GPIO_IN:  rd_data[GPIO_W-1:0] = status_p1;
            OFFS_SCRATCH:  rd_data             = scratch_q;
            default:       rd_data             = '0;
        endcase
    end

    assign common_rst  = ctrl_q[CTRL_COMMON_RST];
    assign common_gate = ctrl_q[CTRL_COMMON_GATE];
    assign switch_on   = ctrl_q[CTRL_SWITCH_ON];
    assign switch_done = ctrl_q[CTRL_SWITCH_DONE];
    assign osw_drive0  = gpio_out_q[GPIO_OSW0];
    assign osw_drive1  = gpio_out_q[GPIO_OSW1];

endmodule

// File: tb/tb_simple_tx_reset_ctl.sv
// Self-checking bench: two instances (byte strobes ignored / honoured with a
// data-phase timeout) driven in lockstep and compared against a register-map model.
module tb_simple_tx_reset_ctl;

    localparam int TO_B = 8;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;

    logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
    logic [1:0]  bresp_a, rresp_a;
    logic [31:0] rdata_a;
    logic        crst_a, cgate_a, son_a, sdone_a, drv0_a, drv1_a;

    logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
    logic [1:0]  bresp_b, rresp_b;
    logic [31:0] rdata_b;
    logic        crst_b, cgate_b, son_b, sdone_b, drv0_b, drv1_b;

    logic [31:0] mdl_a [4];
    logic [31:0] mdl_b [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    simple_tx_reset_ctl #(.C_USE_WSTRB(0), .C_DPHASE_TIMEOUT(0)) dut_a (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_a),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_a),
        .S_AXI_BRESP(bresp_a), .S_AXI_BVALID(bvalid_a), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_a),
        .S_AXI_RDATA(rdata_a), .S_AXI_RRESP(rresp_a), .S_AXI_RVALID(rvalid_a), .S_AXI_RREADY(rready),
        .common_rst(crst_a), .common_gate(cgate_a), .switch_on(son_a), .switch_done(sdone_a),
        .osw_drive0(drv0_a), .osw_drive1(drv1_a), .osw_status0(drv0_a), .osw_status1(drv1_a)
    );

    simple_tx_reset_ctl #(.C_USE_WSTRB(1), .C_DPHASE_TIMEOUT(TO_B)) dut_b (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_b),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_b),
        .S_AXI_BRESP(bresp_b), .S_AXI_BVALID(bvalid_b), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_b),
        .S_AXI_RDATA(rdata_b), .S_AXI_RRESP(rresp_b), .S_AXI_RVALID(rvalid_b), .S_AXI_RREADY(rready),
        .common_rst(crst_b), .common_gate(cgate_b), .switch_on(son_b), .switch_done(sdone_b),
        .osw_drive0(drv0_b), .osw_drive1(drv1_b), .osw_status0(drv0_b), .osw_status1(drv1_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] impl_mask(input int idx);
        case (idx)
            0:       return 32'h0000_000F;
            1:       return 32'h0000_0003;
            2:       return 32'h0000_0003;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] strb_bits(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) begin
            mdl_a[i] = '0;
            mdl_b[i] = '0;
        end
    endtask

    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] s);
        int idx = int'(addr[3:2]);
        logic [31:0] m = strb_bits(s);
        if (idx != 2) begin
            mdl_a[idx] = data & impl_mask(idx);
            mdl_b[idx] = ((mdl_b[idx] & ~m) | (data & m)) & impl_mask(idx);
        end
    endtask

    // GPIO_IN reads back the driven GPIO_OUT through the loopback wiring
    function automatic logic [31:0] exp_rd(input logic [31:0] addr, input bit use_b);
        int idx = int'(addr[3:2]);
        if (idx == 2) idx = 1;
        return use_b ? mdl_b[idx] : mdl_a[idx];
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_ctrl_a"}, {28'b0, sdone_a, son_a, cgate_a, crst_a}, mdl_a[0]);
        check({tag, "_ctrl_b"}, {28'b0, sdone_b, son_b, cgate_b, crst_b}, mdl_b[0]);
        check({tag, "_gpio_a"}, {30'b0, drv1_a, drv0_a}, mdl_a[1]);
        check({tag, "_gpio_b"}, {30'b0, drv1_b, drv0_b}, mdl_b[1]);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_wr_ready();
        int n = 0;
        while (!(awready_a && wready_a) && n < 20) begin
            tick(1);
            n++;
        end
        check("wr_ready", {30'b0, awready_a, wready_a}, 32'h3);
        check("wr_ready_b", {30'b0, awready_b, wready_b}, 32'h3);
    endtask

    task automatic wait_rd_ready();
        int n = 0;
        while (!arready_a && n < 20) begin
            tick(1);
            n++;
        end
        check("rd_ready", {30'b0, arready_a, arready_b}, 32'h3);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] s, input int bdly);
        awaddr = addr; wdata = data; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_wr_ready();
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        mdl_write(addr, data, s);
        check("wr_ready_pulse", {30'b0, awready_a, wready_a}, 32'h0);
        check("bvalid", {30'b0, bvalid_a, bvalid_b}, 32'h3);
        check("bresp", {28'b0, bresp_a, bresp_b}, 32'h0);
        check_outputs($sformatf("wr%0h", addr[3:0]));
        tick(bdly);
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        check("bvalid_clr", {30'b0, bvalid_a, bvalid_b}, 32'h0);
    endtask

    task automatic axi_read_check(input logic [31:0] addr, input int rdly);
        araddr = addr;
        arvalid = 1'b1;
        wait_rd_ready();
        tick(1);
        arvalid = 1'b0;
        check("rvalid", {30'b0, rvalid_a, rvalid_b}, 32'h3);
        check("rresp", {28'b0, rresp_a, rresp_b}, 32'h0);
        check($sformatf("rd%0h_a", addr[3:0]), rdata_a, exp_rd(addr, 1'b0));
        check($sformatf("rd%0h_b", addr[3:0]), rdata_b, exp_rd(addr, 1'b1));
        tick(rdly);
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
        check("rvalid_clr", {30'b0, rvalid_a, rvalid_b}, 32'h0);
    endtask

    initial begin
        logic [31:0] old_a, old_b, d, a;

        awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        aresetn = 1'b0;
        mdl_reset();
        tick(2);
        @(negedge clk);
        aresetn = 1'b1;
        tick(1);

        // reset state
        check_outputs("rst");
        check("rst_hs_a", {27'b0, awready_a, wready_a, bvalid_a, arready_a, rvalid_a}, 32'h0);
        check("rst_hs_b", {27'b0, awready_b, wready_b, bvalid_b, arready_b, rvalid_b}, 32'h0);
        axi_read_check(32'h0, 0);

        // control register
        axi_write(32'h0, 32'h0000_000B, 4'hF, 0);
        check("ctrl_bits", {28'b0, sdone_a, son_a, cgate_a, crst_a}, 32'hB);
        axi_read_check(32'h0, 1);

        // GPIO loopback
        axi_write(32'h4, 32'h3, 4'hF, 0);
        tick(4);
        axi_read_check(32'h8, 0);
        axi_write(32'h4, 32'h1, 4'hF, 2);
        tick(4);
        axi_read_check(32'h8, 0);

        // AW alone must wait for W, and BVALID blocks a second write
        awaddr = 32'hC; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("aw_alone", {30'b0, awready_a, wready_a}, 32'h0);
        end
        wvalid = 1'b1;
        wait_wr_ready();
        tick(1);
        mdl_write(32'hC, 32'h1234_5678, 4'hF);
        awaddr = 32'h0; wdata = 32'h5;
        for (int i = 0; i < 5; i++) begin
            check("bvalid_hold", {30'b0, bvalid_a, bvalid_b}, 32'h3);
            check("no_2nd_accept", {30'b0, awready_a, awready_b}, 32'h0);
            tick(1);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        check_outputs("blocked");
        axi_read_check(32'hC, 0);

        // byte strobes
        axi_write(32'hC, 32'hFFFF_FFFF, 4'hF, 0);
        axi_write(32'hC, 32'h0000_0000, 4'b0010, 0);
        check("wstrb_mdl_b", mdl_b[3], 32'hFFFF_00FF);
        axi_read_check(32'hC, 0);

        // write-response timeout (instance b only)
        awaddr = 32'hC; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_wr_ready();
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        mdl_write(32'hC, 32'hA5A5_0001, 4'hF);
        for (int i = 0; i < TO_B; i++) begin
            check("b_to_hold", {31'b0, bvalid_b}, 32'h1);
            tick(1);
        end
        check("b_to_drop", {30'b0, bvalid_a, bvalid_b}, 32'h2);
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        check("b_to_clr_a", {31'b0, bvalid_a}, 32'h0);

        // read-response timeout (instance b only)
        araddr = 32'hC; arvalid = 1'b1;
        wait_rd_ready();
        tick(1);
        arvalid = 1'b0;
        for (int i = 0; i < TO_B; i++) begin
            check("r_to_hold", {31'b0, rvalid_b}, 32'h1);
            tick(1);
        end
        check("r_to_drop", {30'b0, rvalid_a, rvalid_b}, 32'h2);
        check("r_to_data_a", rdata_a, exp_rd(32'hC, 1'b0));
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
        check("r_to_clr_a", {31'b0, rvalid_a}, 32'h0);

        // simultaneous read and write of the same register returns the old value
        old_a = exp_rd(32'h0, 1'b0);
        old_b = exp_rd(32'h0, 1'b1);
        awaddr = 32'h0; wdata = 32'h6; wstrb = 4'hF; araddr = 32'h0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        wait_wr_ready();
        check("rw_same_ar", {30'b0, arready_a, arready_b}, 32'h3);
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        mdl_write(32'h0, 32'h6, 4'hF);
        check("rw_old_a", rdata_a, old_a);
        check("rw_old_b", rdata_b, old_b);
        check_outputs("rw");
        bready = 1'b1; rready = 1'b1;
        tick(1);
        bready = 1'b0; rready = 1'b0;
        check("rw_clr", {28'b0, bvalid_a, bvalid_b, rvalid_a, rvalid_b}, 32'h0);

        // randomized traffic; upper address bits must be ignored
        for (int k = 0; k < 40; k++) begin
            a = ($urandom & 32'hFFFF_FFF0) | {28'b0, 2'($urandom_range(0, 3)), 2'b00};
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
                tick(4);
            end else begin
                axi_read_check(a, $urandom_range(0, 3));
            end
        end

        // asynchronous reset with a read response still open
        axi_write(32'hC, 32'hDEAD_BEEF, 4'hF, 0);
        araddr = 32'hC; arvalid = 1'b1;
        wait_rd_ready();
        tick(1);
        arvalid = 1'b0;
        check("pre_rst_rvalid", {30'b0, rvalid_a, rvalid_b}, 32'h3);
        #2;
        aresetn = 1'b0;
        #1;
        mdl_reset();
        check("arst_rvalid", {30'b0, rvalid_a, rvalid_b}, 32'h0);
        check("arst_ready", {28'b0, awready_a, arready_a, awready_b, arready_b}, 32'h0);
        check_outputs("arst");
        tick(2);
        @(negedge clk);
        aresetn = 1'b1;
        tick(1);
        axi_read_check(32'hC, 0);
        axi_read_check(32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_tx_reset_ctl.md
Name: simple_tx_reset_ctl

Overview:
AXI4-Lite slave register block for the loopback transmit path.
It drives control levels to the simple_tx datapath (common_rst, common_gate, switch_on, switch_done) and two optical-switch driver GPIOs (osw_drive0/1).
It samples two switch status inputs (osw_status0/1) for software readback.
A single-transaction AXI-Lite master writes and reads it.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 32, AXI address width.
C_USE_WSTRB, 0, 1 = honour S_AXI_WSTRB byte enables; 0 = every write updates all bytes.
C_DPHASE_TIMEOUT, 0, 0 = no timeout; N>0 = drop BVALID/RVALID after N cycles without READY.
C_BASEADDR, 32'hFFFFFFFF, informational only; not used for decode.
C_HIGHADDR, 32'h00000000, informational only; not used for decode.

Ports:
S_AXI_ACLK in 1 clock
S_AXI_ARESETN in 1 async active-low reset
S_AXI_AWADDR in ADDR_W write address
S_AXI_AWVALID in 1; S_AXI_AWREADY out 1
S_AXI_WDATA in DATA_W; S_AXI_WSTRB in DATA_W/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1
S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1
S_AXI_ARADDR in ADDR_W; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1
S_AXI_RDATA out DATA_W; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1
common_rst out 1 datapath reset level
common_gate out 1 datapath transmit gate
switch_on out 1 switch-enable flag to datapath
switch_done out 1 switch-complete flag to datapath
osw_drive0 out 1 switch driver 0
osw_drive1 out 1 switch driver 1
osw_status0 in 1 switch status 0 (asynchronous)
osw_status1 in 1 switch status 1 (asynchronous)

Behaviour:
- One clock, S_AXI_ACLK. Reset S_AXI_ARESETN is asynchronous and active-low; deassertion is synchronous to the clock.
- Reset values: all registers 0, so all control outputs 0. READY and VALID outputs 0; BRESP and RRESP 2'b00.
- Address decode uses AWADDR[3:2] and ARADDR[3:2] only; upper bits are ignored.
- Register map:
  - 0x0 CTRL (RW): [0] common_rst, [1] common_gate, [2] switch_on, [3] switch_done.
  - 0x4 GPIO_OUT (RW): [0] osw_drive0, [1] osw_drive1.
  - 0x8 GPIO_IN (RO): [0] osw_status0, [1] osw_status1, each through a 2-flop synchronizer. Writes are ignored but still get OKAY.
  - 0xC SCRATCH (RW, 32 bits).
  - All unused bits read 0.
- Outputs are driven directly from register bits; a write takes effect the cycle after the AW/W handshake.
- Write channel:
  - AWREADY and WREADY pulse high together for exactly one cycle when AWVALID && WVALID && !BVALID.
  - The register updates on that same edge.
  - BVALID rises the next cycle and holds until BREADY, with BRESP=OKAY.
  - AW arriving without W (or W without AW) waits; neither is accepted alone.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID && !RVALID.
  - The data is registered, and RVALID rises the next cycle and holds until RREADY, with RRESP=OKAY.
- Simultaneous read and write are handled independently.
  - A read of the register being written in the same cycle returns the old value.
- When C_USE_WSTRB=1, only the enabled bytes are written.
- When C_DPHASE_TIMEOUT=N>0, a counter starts when BVALID or RVALID rises. After N cycles without READY, the valid is forced low and the transaction is discarded.
- Reset mid-transaction clears all valid and ready signals immediately; the pending transaction is lost.

Decomposition:
- Shared package: register offsets (CTRL=0x0, GPIO_OUT=0x4, GPIO_IN=0x8, SCRATCH=0xC), bit indices for the CTRL and GPIO fields, and RESP_OKAY=2'b00.
- One sub-module is natural: simple_tx_reset_axil_if. It implements the AXI-Lite handshake and timeout and presents a wr_en/wr_addr/wr_data/wr_strb and rd_addr/rd_data interface to the register file.

Test Plan:
- Reset: hold ARESETN=0 for 2 cycles, then release → all outputs 0; read 0x0 → RDATA=0, RRESP=0.
- Write 0x0=0x0000000B → next cycle common_rst=1, common_gate=1, switch_on=0, switch_done=1; BVALID for one handshake; read back 0x0 = 0xB.
- Loopback: tie osw_status0/1 to osw_drive0/1; write 0x4=0x3 → after ≥3 cycles, read 0x8 = 0x3; write 0x4=0x1 → read 0x8 = 0x1.
- Handshake: present AWVALID 3 cycles before WVALID → no AWREADY until WVALID; hold BREADY=0 for 5 cycles → BVALID stays 1 and no new write is accepted.
- Scratch/WSTRB: with C_USE_WSTRB=1, write 0xC=0xFFFFFFFF and then 0x00000000 with WSTRB=4'b0010 → read 0xC = 0xFFFF00FF. With C_USE_WSTRB=0, the same sequence reads 0.
- Async reset during an open read (RVALID=1, RREADY=0) → RVALID drops immediately, and registers return to 0.
